// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared state encoding and default width for serial_subtractor.
// Revision : 1.0
// ============================================================================
package serial_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : One-bit full subtractor cell, X - Y - Bin -> Diff, Bout.
// Revision : 1.0
// ============================================================================
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    always_comb begin
        Diff = X ^ Y ^ Bin;
        Bout = (~X & Y) | (~(X ^ Y) & Bin);
    end

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor, D = A - B - Bi, LSB first.
//            Define SUB_OVERFLOW_EN to add the signed-overflow output V.
// Revision : 1.0
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_d;
    logic               r_brw;
    logic [c_CNT_W-1:0] r_count;
    logic               w_diff;
    logic               w_nb;

`ifdef SUB_OVERFLOW_EN
    logic               r_a_msb;
    logic               r_b_msb;
`endif

    full_subtractor u_cell (
        .X    (r_a[0]),
        .Y    (r_b[0]),
        .Bin  (r_brw),
        .Diff (w_diff),
        .Bout (w_nb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_brw   <= 1'b0;
            r_count <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bo      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            V       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_brw   <= Bi;
                        r_d     <= '0;
                        r_count <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
`ifdef SUB_OVERFLOW_EN
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_d     <= {w_diff, r_d[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_brw   <= w_nb;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        D       <= {w_diff, r_d[WIDTH-1:1]};
                        Bo      <= w_nb;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
`ifdef SUB_OVERFLOW_EN
                        // w_diff is the result MSB on this final step.
                        V       <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
`endif
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_subtractor
`default_nettype wire
